// File: rtl/sr_drv_pkg.sv
// Shared types and widths for the SR latch pulse driver.
package sr_drv_pkg;

  localparam int CNT_W = 8;  // pulse_count width
  localparam int TMR_W = 8;  // pulse/guard timer width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

endpackage

// File: rtl/sr_latch_pulse_driver_if.sv
// Level-request handshake between an upstream requester and the pulse driver.
interface sr_latch_pulse_driver_if;

  logic req_valid;
  logic req_level;
  logic req_ready;

  modport master (output req_valid, output req_level, input req_ready);
  modport slave  (input req_valid, input req_level, output req_ready);

endinterface

// File: rtl/sr_drv_timer.sv
// Loadable down-counter timing both the pulse and the guard interval.
// done flags the final cycle of an interval (count==1) or an idle/zero count.
module sr_drv_timer
  import sr_drv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] count_q;

  // Load on request, otherwise count down to zero and hold there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {TMR_W{1'b0}};
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != {TMR_W{1'b0}}) begin
      count_q <= count_q - TMR_W'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign done = (count_q == TMR_W'(1)) || (count_q == {TMR_W{1'b0}});

endmodule

// File: rtl/sr_latch_pulse_driver.sv
// Turns level requests into single S or R pulses for a downstream SR latch,
// followed by a guard interval. Tracks the commanded latch level so that
// requests matching the known level are consumed without a pulse.
module sr_latch_pulse_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_W = 4,  // 1..255
  parameter int GUARD_W = 2   // 0..255, 0 skips the guard interval
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sr_latch_pulse_driver_if.slave   req,
  output logic                     s,
  output logic                     r,
  output logic                     busy,
  output logic                     q_model,
  output logic                     q_known,
  output logic [CNT_W-1:0]         pulse_count
);

  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_W);
  localparam logic [TMR_W-1:0] GUARD_LD = TMR_W'(GUARD_W);

  state_e           state_q, state_d;
  logic             target_q, target_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             q_model_q, q_model_d;
  logic             q_known_q, q_known_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_done;

  sr_drv_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .done     (tmr_done)
  );

  // Next-state logic: S and R are only ever driven from the single target bit,
  // so they cannot be high together.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    s_d          = 1'b0;
    r_d          = 1'b0;
    q_model_d    = q_model_q;
    q_known_d    = q_known_q;
    cnt_d        = cnt_q;
    tmr_load     = 1'b0;
    tmr_load_val = {TMR_W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (req.req_valid) begin
          if (q_known_q && (req.req_level == q_model_q)) begin
            state_d = ST_IDLE;  // already at that level: consume silently
          end else begin
            target_d     = req.req_level;
            tmr_load     = 1'b1;
            tmr_load_val = PULSE_LD;
            state_d      = ST_PULSE;
            s_d          = req.req_level;
            r_d          = ~req.req_level;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (tmr_done) begin
          q_model_d = target_q;
          q_known_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          if (GUARD_W == 0) begin
            state_d = ST_IDLE;
          end else begin
            tmr_load     = 1'b1;
            tmr_load_val = GUARD_LD;
            state_d      = ST_GUARD;
          end
        end else begin
          s_d = target_q;
          r_d = ~target_q;
        end
      end
      ST_GUARD: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GUARD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; async reset clears pulses immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      target_q  <= 1'b0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      q_model_q <= 1'b0;
      q_known_q <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      s_q       <= s_d;
      r_q       <= r_d;
      q_model_q <= q_model_d;
      q_known_q <= q_known_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req.req_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign s             = s_q;
  assign r             = r_q;
  assign q_model       = q_model_q;
  assign q_known       = q_known_q;
  assign pulse_count   = cnt_q;

endmodule
